// File: rtl/scpad_xbar.sv
// Requester-to-scratchpad crossbar: per-scratchpad round-robin request arbitration,
// in-order response routing back to the issuing requester through a small tracking FIFO.
module scpad_xbar #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_SCPADS = 2,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 64,
  parameter int TAG_W      = 4,
  parameter int RSP_DEPTH  = 4,
  localparam int SEL_W     = $clog2(NUM_SCPADS),
  localparam int LOC_W     = ADDR_W - SEL_W,
  localparam int CNT_W     = $clog2(RSP_DEPTH) + 1
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]        req_addr,
  input  logic [NUM_REQ-1:0]                    req_wen,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]        req_wdata,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]         req_tag,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [NUM_REQ-1:0][DATA_W-1:0]        rsp_rdata,
  output logic [NUM_REQ-1:0][TAG_W-1:0]         rsp_tag,
  output logic [NUM_SCPADS-1:0]                 sp_req_valid,
  input  logic [NUM_SCPADS-1:0]                 sp_req_ready,
  output logic [NUM_SCPADS-1:0][LOC_W-1:0]      sp_req_addr,
  output logic [NUM_SCPADS-1:0]                 sp_req_wen,
  output logic [NUM_SCPADS-1:0][DATA_W-1:0]     sp_req_wdata,
  input  logic [NUM_SCPADS-1:0]                 sp_rsp_valid,
  output logic [NUM_SCPADS-1:0]                 sp_rsp_ready,
  input  logic [NUM_SCPADS-1:0][DATA_W-1:0]     sp_rsp_rdata,
  output logic [NUM_SCPADS-1:0][CNT_W-1:0]      sp_outstanding,
  output logic                                  err_spurious
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(RSP_DEPTH);

  logic [NUM_SCPADS-1:0][SRC_W-1:0] rr_ptr;
  logic [NUM_SCPADS-1:0][CNT_W-1:0] count;
  logic [NUM_SCPADS-1:0][PTR_W-1:0] wr_ptr;
  logic [NUM_SCPADS-1:0][PTR_W-1:0] rd_ptr;
  logic [SRC_W-1:0]                 fifo_src [NUM_SCPADS][RSP_DEPTH];
  logic [TAG_W-1:0]                 fifo_tag [NUM_SCPADS][RSP_DEPTH];

  logic [NUM_REQ-1:0][SEL_W-1:0]    target;
  logic [NUM_SCPADS-1:0]            grant_found;
  logic [NUM_SCPADS-1:0][SRC_W-1:0] grant_idx;
  logic [NUM_SCPADS-1:0][SRC_W-1:0] head_src;
  logic [NUM_SCPADS-1:0]            full;
  logic [NUM_SCPADS-1:0]            empty;
  logic [NUM_SCPADS-1:0]            push;
  logic [NUM_SCPADS-1:0]            pop;
  logic [NUM_SCPADS-1:0]            rsp_win;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      target[i] = req_addr[i][ADDR_W-1 -: SEL_W];
    end
    for (int s = 0; s < NUM_SCPADS; s++) begin
      full[s]     = (count[s] == CNT_W'(RSP_DEPTH));
      empty[s]    = (count[s] == '0);
      head_src[s] = fifo_src[s][rd_ptr[s]];
    end
  end

  // Round-robin search starts at the pointer and wraps over all requesters.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = '0;
    grant_idx   = '0;
    for (int s = 0; s < NUM_SCPADS; s++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr[s]) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_found[s] && req_valid[idx] && (target[idx] == SEL_W'(s))) begin
          grant_found[s] = 1'b1;
          grant_idx[s]   = SRC_W'(idx);
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SCPADS; s++) begin
      sp_req_valid[s] = nRST && grant_found[s] && !full[s];
      sp_req_addr[s]  = req_addr[grant_idx[s]][LOC_W-1:0];
      sp_req_wen[s]   = req_wen[grant_idx[s]];
      sp_req_wdata[s] = req_wdata[grant_idx[s]];
      push[s]         = sp_req_valid[s] && sp_req_ready[s];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = nRST && grant_found[target[i]] && (grant_idx[target[i]] == SRC_W'(i)) &&
                     sp_req_ready[target[i]] && !full[target[i]];
    end
  end

  // Lower-index scratchpads claim a requester's response slot first.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_tag   = '0;
    rsp_win   = '0;
    for (int s = 0; s < NUM_SCPADS; s++) begin
      if (nRST && sp_rsp_valid[s] && !empty[s] && !rsp_valid[head_src[s]]) begin
        rsp_win[s]                = 1'b1;
        rsp_valid[head_src[s]]    = 1'b1;
        rsp_rdata[head_src[s]]    = sp_rsp_rdata[s];
        rsp_tag[head_src[s]]      = fifo_tag[s][rd_ptr[s]];
      end
    end
    sp_rsp_ready = empty | rsp_win;
    pop          = sp_rsp_valid & rsp_win;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr       <= '0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_spurious <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SCPADS; s++) begin
        if (push[s]) begin
          wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
          rr_ptr[s] <= (grant_idx[s] == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx[s] + SRC_W'(1);
        end
        if (pop[s]) rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        if (push[s] && !pop[s]) count[s] <= count[s] + CNT_W'(1);
        else if (!push[s] && pop[s]) count[s] <= count[s] - CNT_W'(1);
        if (sp_rsp_valid[s] && empty[s]) err_spurious <= 1'b1;
      end
    end
  end

  // Tracking payload needs no reset; occupancy is governed by the pointers.
  always_ff @(posedge CLK) begin
    for (int s = 0; s < NUM_SCPADS; s++) begin
      if (push[s]) begin
        fifo_src[s][wr_ptr[s]] <= grant_idx[s];
        fifo_tag[s][wr_ptr[s]] <= req_tag[grant_idx[s]];
      end
    end
  end

  assign sp_outstanding = count;

endmodule
